// File: rtl/xdn_pkg.sv
// Shared definitions for the XDN CPU program loader: the loader state
// encoding and the bit positions of the control strobes that the CPU
// top level ORs into its own MAR/RAM control lines.
package xdn_pkg;

  typedef enum logic [2:0] {
    LD_IDLE      = 3'd0,
    LD_HOLD      = 3'd1,
    LD_WAIT_BYTE = 3'd2,
    LD_ADDR      = 3'd3,
    LD_DATA      = 3'd4,
    LD_VERIFY    = 3'd5,
    LD_RELEASE   = 3'd6
  } loader_state_t;

  localparam int STROBE_MAR_IN  = 0;
  localparam int STROBE_RAM_IN  = 1;
  localparam int STROBE_RAM_OUT = 2;
  localparam int STROBE_COUNT   = 3;

endpackage

// File: rtl/load_address_counter.sv
// Target address counter for the program loader. Clears to zero, steps
// by one on request and flags the last RAM word so the loader can stop
// without ever wrapping back to address zero.
module load_address_counter #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int RAM_LENGTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     incr,
  output logic [ADDRESS_WIDTH-1:0] count,
  output logic                     terminal
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(RAM_LENGTH - 1);

  // Address register: clear wins over increment, and the terminal word holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr && !terminal) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == LAST_ADDR);

endmodule

// File: rtl/ram_loader.sv
// Program-load controller for the XDN 8-bit CPU. Holds the CPU halted,
// takes the bus, and writes bytes arriving over a valid/ready handshake
// into RAM (MAR strobe with the address, then RAM strobe with the byte).
// Optional build macro RAM_LOADER_VERIFY_EN adds a read-back VERIFY
// state with a sticky mismatch flag and the o_RAM_OUT / i_BUS ports.
module ram_loader #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int RAM_LENGTH    = 16
) (
  input  logic                     i_CLOCK,
  input  logic                     i_CLEAR_n,
  input  logic                     i_LOAD_REQ,
  input  logic                     i_CPU_IDLE,
  input  logic                     i_WR_VALID,
  input  logic [DATA_WIDTH-1:0]    i_WR_DATA,
  input  logic                     i_WR_LAST,
`ifdef RAM_LOADER_VERIFY_EN
  input  logic [DATA_WIDTH-1:0]    i_BUS,
  output logic                     o_RAM_OUT,
  output logic                     o_VERIFY_ERR,
`endif
  output logic                     o_WR_READY,
  output logic                     o_CPU_HOLD,
  output logic                     o_BUS_DRIVE,
  output logic [DATA_WIDTH-1:0]    o_BUS_DATA,
  output logic                     o_MAR_IN,
  output logic                     o_RAM_IN,
  output logic [ADDRESS_WIDTH-1:0] o_ADDR,
  output logic                     o_BUSY,
  output logic                     o_DONE
);

  import xdn_pkg::*;

  loader_state_t             state, next_state;
  logic [STROBE_COUNT-1:0]   strobes;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      last_q;
  logic                      latch_en;
  logic                      addr_clear;
  logic                      addr_incr;
  logic                      terminal;
  logic                      load_start;

  load_address_counter #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .RAM_LENGTH    (RAM_LENGTH)
  ) u_addr (
    .clk      (i_CLOCK),
    .rst_n    (i_CLEAR_n),
    .clear    (addr_clear),
    .incr     (addr_incr),
    .count    (o_ADDR),
    .terminal (terminal)
  );

  // State register; reset drops straight back to IDLE even mid-byte.
  always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      state <= LD_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Byte and last-flag latch, loaded on the valid/ready handshake.
  always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      data_q <= '0;
      last_q <= 1'b0;
    end else if (latch_en) begin
      data_q <= i_WR_DATA;
      last_q <= i_WR_LAST;
    end
  end

  // Next-state and output decode; every output is a function of state only.
  always_comb begin
    next_state  = state;
    strobes     = '0;
    o_WR_READY  = 1'b0;
    o_CPU_HOLD  = 1'b0;
    o_BUS_DRIVE = 1'b0;
    o_BUS_DATA  = '0;
    o_DONE      = 1'b0;
    addr_clear  = 1'b0;
    addr_incr   = 1'b0;
    latch_en    = 1'b0;
    load_start  = 1'b0;
    case (state)
      LD_IDLE: begin
        addr_clear = 1'b1;
        if (i_LOAD_REQ) begin
          load_start = 1'b1;
          next_state = LD_HOLD;
        end
      end
      LD_HOLD: begin
        o_CPU_HOLD = 1'b1;
        if (i_CPU_IDLE) next_state = LD_WAIT_BYTE;
      end
      LD_WAIT_BYTE: begin
        o_CPU_HOLD = 1'b1;
        o_WR_READY = 1'b1;
        if (i_WR_VALID) begin
          latch_en   = 1'b1;
          next_state = LD_ADDR;
        end
      end
      LD_ADDR: begin
        o_CPU_HOLD             = 1'b1;
        o_BUS_DRIVE            = 1'b1;
        o_BUS_DATA             = DATA_WIDTH'(o_ADDR);
        strobes[STROBE_MAR_IN] = 1'b1;
        next_state             = LD_DATA;
      end
      LD_DATA: begin
        o_CPU_HOLD             = 1'b1;
        o_BUS_DRIVE            = 1'b1;
        o_BUS_DATA             = data_q;
        strobes[STROBE_RAM_IN] = 1'b1;
`ifdef RAM_LOADER_VERIFY_EN
        next_state = LD_VERIFY;
`else
        if (last_q || terminal) begin
          next_state = LD_RELEASE;
        end else begin
          addr_incr  = 1'b1;
          next_state = LD_WAIT_BYTE;
        end
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      LD_VERIFY: begin
        o_CPU_HOLD              = 1'b1;
        strobes[STROBE_RAM_OUT] = 1'b1;
        if (last_q || terminal) begin
          next_state = LD_RELEASE;
        end else begin
          addr_incr  = 1'b1;
          next_state = LD_WAIT_BYTE;
        end
      end
`endif
      LD_RELEASE: begin
        o_DONE     = 1'b1;
        addr_clear = 1'b1;
        next_state = LD_IDLE;
      end
      default: begin
        next_state = LD_IDLE;
      end
    endcase
  end

  assign o_MAR_IN = strobes[STROBE_MAR_IN];
  assign o_RAM_IN = strobes[STROBE_RAM_IN];
  assign o_BUSY   = (state != LD_IDLE);

`ifdef RAM_LOADER_VERIFY_EN
  logic verify_err_q;

  // Sticky read-back mismatch flag, cleared when a new load starts.
  always_ff @(posedge i_CLOCK or negedge i_CLEAR_n) begin
    if (!i_CLEAR_n) begin
      verify_err_q <= 1'b0;
    end else if (load_start) begin
      verify_err_q <= 1'b0;
    end else if (state == LD_VERIFY && i_BUS != data_q) begin
      verify_err_q <= 1'b1;
    end
  end

  assign o_RAM_OUT    = strobes[STROBE_RAM_OUT];
  assign o_VERIFY_ERR = verify_err_q;
`else
  logic unused_ram_out;
  logic unused_load_start;
  assign unused_ram_out    = strobes[STROBE_RAM_OUT];
  assign unused_load_start = load_start;
`endif

endmodule
